axil_regbus_bridge: RTL and testbench



---
 rtl/axil_bridge_pkg.sv | 29 ++
 rtl/axil_hold_reg.sv | 29 ++
 rtl/axil_regbus_bridge.sv | 184 ++++++++++++++++++
 tb/tb_axil_regbus_bridge.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_bridge_pkg.sv
// Shared types and helpers for the AXI4-Lite to REG_BUS bridge.
package axil_bridge_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    IDLE,
    WR_ISSUE,
    WR_RESP,
    RD_ISSUE,
    RD_WAIT,
    RD_RESP
  } state_t;

  typedef enum logic {
    WRITE = 1'b0,
    READ  = 1'b1
  } grant_t;

  // Number of byte-address bits below one data word.
  function automatic int addr_lsb(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/axil_hold_reg.sv
// One-entry valid/ready holding register: accepts while empty, stays full until popped.
module axil_hold_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid,
  output logic         ready,
  input  logic [W-1:0] d,
  input  logic         pop,
  output logic         held,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held <= 1'b0;
      q    <= '0;
    end else if (valid && !held) begin
      held <= 1'b1;
      q    <= d;
    end else if (pop) begin
      held <= 1'b0;
    end
  end

  assign ready = ~held;

endmodule

// File: rtl/axil_regbus_bridge.sv
// AXI4-Lite slave to REG_BUS master bridge with fair write/read arbitration,
// window decode errors and a read timeout so a silent register file never hangs the host.
module axil_regbus_bridge
  import axil_bridge_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter int                    ADDR_SPAN    = 4096,
  parameter int                    RD_TIMEOUT   = 255,
  parameter logic [31:0]           TIMEOUT_DATA = 32'hDEAD_BEEF
) (
  input  logic                    clk,
  input  logic                    rst,
  // Handshake rule on every channel: a beat transfers on a rising edge where valid
  // and ready are both 1; valid and payload stay stable until that edge.
  input  logic [ADDR_WIDTH-1:0]   s_axil_awaddr,
  input  logic [2:0]              s_axil_awprot,
  input  logic                    s_axil_awvalid,
  output logic                    s_axil_awready,
  input  logic [DATA_WIDTH-1:0]   s_axil_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axil_wstrb,
  input  logic                    s_axil_wvalid,
  output logic                    s_axil_wready,
  output logic [1:0]              s_axil_bresp,
  output logic                    s_axil_bvalid,
  input  logic                    s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axil_araddr,
  input  logic [2:0]              s_axil_arprot,
  input  logic                    s_axil_arvalid,
  output logic                    s_axil_arready,
  output logic [DATA_WIDTH-1:0]   s_axil_rdata,
  output logic [1:0]              s_axil_rresp,
  output logic                    s_axil_rvalid,
  input  logic                    s_axil_rready,
  output logic                    m_reg_wren,
  output logic [ADDR_WIDTH-1:0]   m_reg_waddr,
  output logic [DATA_WIDTH-1:0]   m_reg_wdata,
  output logic [DATA_WIDTH/8-1:0] m_reg_wstrb,
  output logic                    m_reg_rden,
  output logic [ADDR_WIDTH-1:0]   m_reg_raddr,
  input  logic [DATA_WIDTH-1:0]   m_reg_rdata,
  input  logic                    m_reg_rvld,
  output state_t                  dbg_state
);

  localparam int                    LSB        = addr_lsb(DATA_WIDTH);
  localparam int                    SW         = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << LSB;
  localparam logic [ADDR_WIDTH-1:0] SPAN       = ADDR_WIDTH'(ADDR_SPAN);
  localparam logic [DATA_WIDTH-1:0] TO_PATTERN = {(DATA_WIDTH/32){TIMEOUT_DATA}};
  localparam logic [15:0]           TO_COUNT   = 16'(RD_TIMEOUT);

  state_t                   state, state_d;
  grant_t                   last_grant;
  logic [15:0]              cnt;
  resp_t                    bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0]    rdata_q;
  logic                     aw_held, w_held, ar_held, aw_pop, w_pop, ar_pop;
  logic [ADDR_WIDTH-1:0]    aw_q, ar_q, wr_off, rd_off;
  logic [DATA_WIDTH+SW-1:0] w_q;
  logic                     wr_hit, rd_hit, grant_wr, grant_rd, rd_done, rd_expired;
  logic                     unused_prot;

  assign unused_prot = ^{s_axil_awprot, s_axil_arprot};

  axil_hold_reg #(.W(ADDR_WIDTH)) u_aw (
    .clk(clk), .rst(rst), .valid(s_axil_awvalid), .ready(s_axil_awready),
    .d(s_axil_awaddr), .pop(aw_pop), .held(aw_held), .q(aw_q));
  axil_hold_reg #(.W(DATA_WIDTH + SW)) u_w (
    .clk(clk), .rst(rst), .valid(s_axil_wvalid), .ready(s_axil_wready),
    .d({s_axil_wstrb, s_axil_wdata}), .pop(w_pop), .held(w_held), .q(w_q));
  axil_hold_reg #(.W(ADDR_WIDTH)) u_ar (
    .clk(clk), .rst(rst), .valid(s_axil_arvalid), .ready(s_axil_arready),
    .d(s_axil_araddr), .pop(ar_pop), .held(ar_held), .q(ar_q));

  // Unsigned wrap-around makes addresses below BASE_ADDR decode as out of range.
  assign wr_off     = aw_q - BASE_ADDR;
  assign rd_off     = ar_q - BASE_ADDR;
  assign wr_hit     = wr_off < SPAN;
  assign rd_hit     = rd_off < SPAN;
  assign grant_wr   = aw_held && w_held && (!ar_held || last_grant == READ);
  assign grant_rd   = ar_held && !grant_wr;
  assign rd_done    = m_reg_rvld && (state == RD_ISSUE || state == RD_WAIT);
  assign rd_expired = (state == RD_WAIT) && (cnt >= TO_COUNT);
  assign dbg_state  = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (grant_wr)      state_d = wr_hit ? WR_ISSUE : WR_RESP;
        else if (grant_rd) state_d = rd_hit ? RD_ISSUE : RD_RESP;
      end
      WR_ISSUE: state_d = WR_RESP;
      WR_RESP:  if (s_axil_bready) state_d = IDLE;
      RD_ISSUE: state_d = m_reg_rvld ? RD_RESP : RD_WAIT;
      RD_WAIT:  if (m_reg_rvld || rd_expired) state_d = RD_RESP;
      RD_RESP:  if (s_axil_rready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // REG_BUS fields are forced to 0 outside their strobe cycle.
  always_comb begin
    m_reg_wren    = 1'b0;
    m_reg_waddr   = '0;
    m_reg_wdata   = '0;
    m_reg_wstrb   = '0;
    m_reg_rden    = 1'b0;
    m_reg_raddr   = '0;
    aw_pop        = 1'b0;
    w_pop         = 1'b0;
    ar_pop        = 1'b0;
    s_axil_bvalid = (state == WR_RESP);
    s_axil_rvalid = (state == RD_RESP);
    case (state)
      IDLE: begin
        if (grant_wr && !wr_hit) begin
          aw_pop = 1'b1;
          w_pop  = 1'b1;
        end
        if (grant_rd && !rd_hit) ar_pop = 1'b1;
      end
      WR_ISSUE: begin
        m_reg_wren  = 1'b1;
        m_reg_waddr = wr_off & ALIGN_MASK;
        m_reg_wdata = w_q[DATA_WIDTH-1:0];
        m_reg_wstrb = w_q[DATA_WIDTH+SW-1:DATA_WIDTH];
        aw_pop      = 1'b1;
        w_pop       = 1'b1;
      end
      RD_ISSUE: begin
        m_reg_rden  = 1'b1;
        m_reg_raddr = rd_off;
        ar_pop      = 1'b1;
      end
      default: ;
    endcase
  end

  // Response payloads are set on entry to the response state and held until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= READ;
      cnt        <= '0;
      bresp_q    <= OKAY;
      rresp_q    <= OKAY;
      rdata_q    <= '0;
    end else begin
      if (state == IDLE) begin
        if (grant_wr) begin
          last_grant <= WRITE;
          bresp_q    <= wr_hit ? OKAY : DECERR;
        end else if (grant_rd) begin
          last_grant <= READ;
          if (!rd_hit) begin
            rdata_q <= '0;
            rresp_q <= DECERR;
          end
        end
      end
      if (state == RD_ISSUE)     cnt <= 16'd1;
      else if (state == RD_WAIT) cnt <= cnt + 16'd1;
      if (rd_done) begin
        rdata_q <= m_reg_rdata;
        rresp_q <= OKAY;
      end else if (rd_expired) begin
        rdata_q <= TO_PATTERN;
        rresp_q <= SLVERR;
      end
    end
  end

  assign s_axil_bresp = bresp_q;
  assign s_axil_rresp = rresp_q;
  assign s_axil_rdata = rdata_q;

endmodule

// File: tb/tb_axil_regbus_bridge.sv
// Directed bench for axil_regbus_bridge: window 0x1000..0x10FF, read timeout of 8 cycles.
module tb_axil_regbus_bridge;
  import axil_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_axil_awaddr, s_axil_wdata, s_axil_araddr, s_axil_rdata;
  logic [2:0]  s_axil_awprot, s_axil_arprot;
  logic [3:0]  s_axil_wstrb, m_reg_wstrb;
  logic        s_axil_awvalid, s_axil_awready, s_axil_wvalid, s_axil_wready;
  logic [1:0]  s_axil_bresp, s_axil_rresp;
  logic        s_axil_bvalid, s_axil_bready, s_axil_arvalid, s_axil_arready;
  logic        s_axil_rvalid, s_axil_rready;
  logic        m_reg_wren, m_reg_rden, m_reg_rvld;
  logic [31:0] m_reg_waddr, m_reg_wdata, m_reg_raddr, m_reg_rdata;
  state_t      dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  axil_regbus_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(32'h0000_1000), .ADDR_SPAN(256),
    .RD_TIMEOUT(8), .TIMEOUT_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
    .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
    .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
    .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
    .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .m_reg_wren(m_reg_wren), .m_reg_waddr(m_reg_waddr), .m_reg_wdata(m_reg_wdata),
    .m_reg_wstrb(m_reg_wstrb), .m_reg_rden(m_reg_rden), .m_reg_raddr(m_reg_raddr),
    .m_reg_rdata(m_reg_rdata), .m_reg_rvld(m_reg_rvld), .dbg_state(dbg_state)
  );

  // Edge monitor: counts strobes, logs grant order (1 = write, 0 = read) and edge timing.
  int          cyc = 0, wren_cnt = 0, rden_cnt = 0, b_rises = 0, r_rises = 0;
  int          wren_cyc = 0, rvld_cyc = 0, b_rise_cyc = 0, r_rise_cyc = 0;
  logic        bvalid_d = 1'b0, rvalid_d = 1'b0;
  logic [31:0] last_waddr = '0, last_wdata = '0, last_raddr = '0;
  logic [3:0]  last_wstrb = '0;
  logic [7:0]  grant_hist = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m_reg_wren) begin
      wren_cnt   <= wren_cnt + 1;
      wren_cyc   <= cyc;
      last_waddr <= m_reg_waddr;
      last_wdata <= m_reg_wdata;
      last_wstrb <= m_reg_wstrb;
      grant_hist <= {grant_hist[6:0], 1'b1};
    end
    if (m_reg_rden) begin
      rden_cnt   <= rden_cnt + 1;
      last_raddr <= m_reg_raddr;
      grant_hist <= {grant_hist[6:0], 1'b0};
    end
    if (m_reg_rvld) rvld_cyc <= cyc;
    if (s_axil_bvalid && !bvalid_d) begin
      b_rise_cyc <= cyc;
      b_rises    <= b_rises + 1;
    end
    if (s_axil_rvalid && !rvalid_d) begin
      r_rise_cyc <= cyc;
      r_rises    <= r_rises + 1;
    end
    bvalid_d <= s_axil_bvalid;
    rvalid_d <= s_axil_rvalid;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic use_aw, input logic use_w, input logic use_ar,
                          input string tag);
    logic aw_done, w_done, ar_done, aw_hs, w_hs, ar_hs;
    aw_done = !use_aw;
    w_done  = !use_w;
    ar_done = !use_ar;
    s_axil_awvalid = use_aw;
    s_axil_wvalid  = use_w;
    s_axil_arvalid = use_ar;
    for (int i = 0; i < 20 && !(aw_done && w_done && ar_done); i++) begin
      aw_hs = s_axil_awvalid && s_axil_awready;
      w_hs  = s_axil_wvalid && s_axil_wready;
      ar_hs = s_axil_arvalid && s_axil_arready;
      tick();
      if (aw_hs) begin s_axil_awvalid = 1'b0; aw_done = 1'b1; end
      if (w_hs)  begin s_axil_wvalid  = 1'b0; w_done  = 1'b1; end
      if (ar_hs) begin s_axil_arvalid = 1'b0; ar_done = 1'b1; end
    end
    check({tag, "_accept"}, 64'({aw_done, w_done, ar_done}), 64'(3'b111));
    s_axil_awvalid = 1'b0;
    s_axil_wvalid  = 1'b0;
    s_axil_arvalid = 1'b0;
  endtask

  task automatic wait_b(input logic [1:0] exp_resp, input int hold, input string tag);
    for (int i = 0; i < 30 && !s_axil_bvalid; i++) tick();
    check({tag, "_bvalid"}, 64'(s_axil_bvalid), 64'(1));
    for (int k = 0; k < hold; k++) begin
      check({tag, "_bhold"}, 64'({s_axil_bvalid, s_axil_bresp}), 64'({1'b1, exp_resp}));
      tick();
    end
    check({tag, "_bresp"}, 64'(s_axil_bresp), 64'(exp_resp));
    s_axil_bready = 1'b1;
    tick();
    s_axil_bready = 1'b0;
  endtask

  task automatic wait_r(input logic [31:0] exp_data, input logic [1:0] exp_resp,
                        input int hold, input string tag);
    for (int i = 0; i < 30 && !s_axil_rvalid; i++) tick();
    check({tag, "_rvalid"}, 64'(s_axil_rvalid), 64'(1));
    for (int k = 0; k < hold; k++) begin
      check({tag, "_rhold"}, 64'({s_axil_rvalid, s_axil_rresp, s_axil_rdata}),
            64'({1'b1, exp_resp, exp_data}));
      tick();
    end
    check({tag, "_rdata"}, 64'(s_axil_rdata), 64'(exp_data));
    check({tag, "_rresp"}, 64'(s_axil_rresp), 64'(exp_resp));
    s_axil_rready = 1'b1;
    tick();
    s_axil_rready = 1'b0;
  endtask

  task automatic wait_rden(input string tag);
    for (int i = 0; i < 30 && !m_reg_rden; i++) tick();
    check({tag, "_rden"}, 64'(m_reg_rden), 64'(1));
  endtask

  task automatic pulse_rvld(input logic [31:0] data);
    m_reg_rvld  = 1'b1;
    m_reg_rdata = data;
    tick();
    m_reg_rvld  = 1'b0;
    m_reg_rdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n0, r0, b0, rr0;
    rst = 1'b1;
    s_axil_awaddr = '0; s_axil_awprot = 3'b010; s_axil_awvalid = 1'b0;
    s_axil_wdata = '0; s_axil_wstrb = '0; s_axil_wvalid = 1'b0;
    s_axil_bready = 1'b0; s_axil_araddr = '0; s_axil_arprot = 3'b101;
    s_axil_arvalid = 1'b0; s_axil_rready = 1'b0;
    m_reg_rdata = '0; m_reg_rvld = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("reset_ready", 64'({s_axil_awready, s_axil_wready, s_axil_arready}), 64'(3'b111));
    check("reset_resp", 64'({s_axil_bvalid, s_axil_rvalid, s_axil_bresp, s_axil_rresp}), 64'(0));
    check("reset_rdata", 64'(s_axil_rdata), 64'(0));
    check("reset_strobes", 64'({m_reg_wren, m_reg_rden, m_reg_wstrb}), 64'(0));
    check("reset_waddr", 64'(m_reg_waddr), 64'(0));
    check("reset_state", 64'(dbg_state), 64'(IDLE));

    // Single write, AW and W together
    s_axil_awaddr = 32'h0000_1010; s_axil_wdata = 32'h1234_5678; s_axil_wstrb = 4'hF;
    n0 = wren_cnt;
    send_req(1'b1, 1'b1, 1'b0, "wr1");
    wait_b(OKAY, 0, "wr1");
    check("wr1_wren_count", 64'(wren_cnt - n0), 64'(1));
    check("wr1_waddr", 64'(last_waddr), 64'h10);
    check("wr1_wdata", 64'(last_wdata), 64'h1234_5678);
    check("wr1_wstrb", 64'(last_wstrb), 64'hF);
    check("wr1_b_after_wren", 64'(b_rise_cyc - wren_cyc), 64'(1));

    // W three cycles ahead of AW, unaligned address
    s_axil_wdata = 32'hA5A5_0F0F; s_axil_wstrb = 4'h3;
    n0 = wren_cnt;
    send_req(1'b0, 1'b1, 1'b0, "wfirst_w");
    check("wfirst_wready_low", 64'(s_axil_wready), 64'(0));
    tick();
    tick();
    check("wfirst_no_early_wren", 64'(wren_cnt - n0), 64'(0));
    s_axil_awaddr = 32'h0000_1047;
    send_req(1'b1, 1'b0, 1'b0, "wfirst_aw");
    wait_b(OKAY, 0, "wfirst");
    check("wfirst_wren_count", 64'(wren_cnt - n0), 64'(1));
    check("wfirst_waddr", 64'(last_waddr), 64'h44);
    check("wfirst_wdata", 64'(last_wdata), 64'hA5A5_0F0F);
    check("wfirst_wstrb", 64'(last_wstrb), 64'h3);
    check("wfirst_wready_back", 64'(s_axil_wready), 64'(1));

    // Read answered five cycles after rden
    s_axil_araddr = 32'h0000_1020;
    r0 = rden_cnt;
    send_req(1'b0, 1'b0, 1'b1, "rd1");
    wait_rden("rd1");
    check("rd1_raddr", 64'(m_reg_raddr), 64'h20);
    repeat (5) tick();
    pulse_rvld(32'hCAFE_0001);
    wait_r(32'hCAFE_0001, OKAY, 0, "rd1");
    check("rd1_r_after_rvld", 64'(r_rise_cyc - rvld_cyc), 64'(1));
    check("rd1_rden_count", 64'(rden_cnt - r0), 64'(1));

    // Silent responder: timeout, late rvld ignored, next read clean
    s_axil_araddr = 32'h0000_1030;
    send_req(1'b0, 1'b0, 1'b1, "to");
    wait_rden("to");
    repeat (8) tick();
    check("to_not_early", 64'(s_axil_rvalid), 64'(0));
    tick();
    check("to_on_time", 64'(s_axil_rvalid), 64'(1));
    wait_r(32'hDEAD_BEEF, SLVERR, 0, "to");
    tick();
    pulse_rvld(32'hBAD0_BAD0);
    tick();
    check("late_rvld_ignored", 64'({s_axil_rvalid, dbg_state}), 64'({1'b0, IDLE}));
    s_axil_araddr = 32'h0000_1040;
    send_req(1'b0, 1'b0, 1'b1, "rd2");
    wait_rden("rd2");
    check("rd2_raddr", 64'(m_reg_raddr), 64'h40);
    pulse_rvld(32'h5555_AAAA);
    wait_r(32'h5555_AAAA, OKAY, 0, "rd2");

    // Out-of-window write above and read below the window
    s_axil_awaddr = 32'h0000_1100; s_axil_wdata = 32'h0BAD_F00D; s_axil_wstrb = 4'hF;
    n0 = wren_cnt;
    r0 = rden_cnt;
    send_req(1'b1, 1'b1, 1'b0, "oow_wr");
    wait_b(DECERR, 0, "oow_wr");
    s_axil_araddr = 32'h0000_0FFC;
    send_req(1'b0, 1'b0, 1'b1, "oow_rd");
    wait_r(32'h0, DECERR, 0, "oow_rd");
    check("oow_no_strobes", 64'({wren_cnt - n0, rden_cnt - r0}), 64'(0));

    // Contention with backpressure: grants alternate starting with write
    for (int it = 0; it < 4; it++) begin
      s_axil_awaddr = 32'h0000_1080 + 32'(it * 8);
      s_axil_wdata  = 32'h1000_0000 + 32'(it);
      s_axil_wstrb  = 4'hF;
      s_axil_araddr = 32'h0000_10C0 + 32'(it * 4);
      r0 = rden_cnt;
      send_req(1'b1, 1'b1, 1'b1, "cont");
      wait_b(OKAY, 2, "cont_w");
      check("cont_read_waits", 64'(rden_cnt - r0), 64'(0));
      check("cont_waddr", 64'(last_waddr), 64'(32'h80 + 32'(it * 8)));
      wait_rden("cont_r");
      pulse_rvld(32'hBEEF_0000 + 32'(it));
      wait_r(32'hBEEF_0000 + 32'(it), OKAY, 2, "cont_r");
    end
    check("cont_grant_order", 64'(grant_hist), 64'hAA);

    // Reset while waiting for rvld: outputs drop at once, no response afterwards
    s_axil_araddr = 32'h0000_1050;
    send_req(1'b0, 1'b0, 1'b1, "rst");
    wait_rden("rst");
    tick();
    tick();
    check("rst_in_wait", 64'(dbg_state), 64'(RD_WAIT));
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_outputs", 64'({m_reg_wren, m_reg_rden, s_axil_bvalid, s_axil_rvalid}), 64'(0));
    check("rst_async_state", 64'({dbg_state, s_axil_awready, s_axil_wready, s_axil_arready}),
          64'({IDLE, 3'b111}));
    tick();
    rst = 1'b0;
    r0 = rden_cnt;
    b0 = b_rises;
    rr0 = r_rises;
    pulse_rvld(32'h7777_7777);
    repeat (10) tick();
    check("rst_no_response", 64'({r_rises - rr0, b_rises - b0}), 64'(0));
    check("rst_no_strobe", 64'(rden_cnt - r0), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
